// File: rtl/trng_sampler_ctrl.sv
// trng_sampler_ctrl: sequences a 2:1 ring-oscillator mux and samples each source in turn.
// Each output bit is the XOR of one source-0 sample and one source-1 sample. Bits are
// packed LSB-first into WIDTH-bit words and handed over on a valid/ready handshake.
// Optional build macro: TRNG_HEALTH_EN adds a repetition-count health test with a
// sticky FAULT state.
module trng_sampler_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLE_DIV    = 16,
    parameter int unsigned REP_LIMIT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mux_y,
    output logic             mux_sel,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             health_fail
);

    localparam int unsigned P  = SETTLE_CYCLES + SAMPLE_DIV;
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PLast = PW'(P - 1);
    localparam logic [BW-1:0] BLast = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPhase0,
        StPhase1,
        StHold,
        StFault
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] rnd_data_q, rnd_data_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic             mux_sel_q, mux_sel_d;
    logic             a_q, a_d;
    logic             lead_q, lead_d;
    logic [1:0]       sync_q;
    logic             ys;
    logic             sample;
    logic             new_bit;
    logic [WIDTH-1:0] new_word;
    logic             fault_hit;
    logic             clr_run;

    // Two-flop synchronizer for the asynchronous mux output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], mux_y};
        end
    end

    assign ys       = sync_q[1];
    // lead_q inserts one idle phase cycle after IDLE exit so the first word has the same
    // latency as the steady-state word period (which includes the HOLD cycle).
    assign sample   = (pcnt_q == PLast) && !lead_q;
    assign new_bit  = a_q ^ ys;
    assign new_word = {new_bit, shreg_q[WIDTH-1:1]};

`ifdef TRNG_HEALTH_EN
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] RLimit = RW'(REP_LIMIT);

    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_next;
    logic          prev_q, prev_d;
    logic          health_fail_q, health_fail_d;

    // Run length of the combined bit stream, including the bit being produced now
    always_comb begin
        rcnt_next = RW'(1);
        if ((rcnt_q != '0) && (new_bit == prev_q)) begin
            rcnt_next = rcnt_q + RW'(1);
        end
    end

    assign fault_hit = (state_q == StPhase1) && sample && (rcnt_next == RLimit);

    // Health state: updated on every produced bit, cleared on IDLE entry, sticky fail flag
    always_comb begin
        rcnt_d        = rcnt_q;
        prev_d        = prev_q;
        health_fail_d = health_fail_q | fault_hit;
        if (clr_run) begin
            rcnt_d = '0;
            prev_d = 1'b0;
        end else if ((state_q == StPhase1) && sample) begin
            rcnt_d = rcnt_next;
            prev_d = new_bit;
        end
    end

    // Health registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q        <= '0;
            prev_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            rcnt_q        <= rcnt_d;
            prev_q        <= prev_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign health_fail = health_fail_q;
`else
    assign fault_hit   = 1'b0;
    assign health_fail = 1'b0;
`endif

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q;
        mux_sel_d   = mux_sel_q;
        a_d         = a_q;
        lead_d      = lead_q;
        clr_run     = 1'b0;
        unique case (state_q)
            StIdle: begin
                mux_sel_d = 1'b0;
                if (ena) begin
                    state_d = StPhase0;
                    pcnt_d  = '0;
                    bcnt_d  = '0;
                    shreg_d = '0;
                    lead_d  = 1'b1;
                end
            end
            StPhase0, StPhase1: begin
                if (!ena) begin
                    // Abort: the partial word is dropped
                    state_d   = StIdle;
                    pcnt_d    = '0;
                    bcnt_d    = '0;
                    shreg_d   = '0;
                    lead_d    = 1'b0;
                    mux_sel_d = 1'b0;
                    clr_run   = 1'b1;
                end else if (lead_q) begin
                    lead_d = 1'b0;
                end else if (!sample) begin
                    pcnt_d = pcnt_q + PW'(1);
                end else if (state_q == StPhase0) begin
                    a_d       = ys;
                    pcnt_d    = '0;
                    state_d   = StPhase1;
                    mux_sel_d = 1'b1;
                end else begin
                    shreg_d   = new_word;
                    pcnt_d    = '0;
                    mux_sel_d = 1'b0;
                    if (fault_hit) begin
                        state_d = StFault;
                    end else if (bcnt_q == BLast) begin
                        state_d     = StHold;
                        bcnt_d      = '0;
                        rnd_data_d  = new_word;
                        rnd_valid_d = 1'b1;
                    end else begin
                        state_d = StPhase0;
                        bcnt_d  = bcnt_q + BW'(1);
                    end
                end
            end
            StHold: begin
                mux_sel_d = 1'b0;
                if (rnd_ready) begin
                    rnd_valid_d = 1'b0;
                    bcnt_d      = '0;
                    pcnt_d      = '0;
                    if (ena) begin
                        state_d = StPhase0;
                    end else begin
                        state_d = StIdle;
                        shreg_d = '0;
                        clr_run = 1'b1;
                    end
                end
            end
            StFault: begin
                mux_sel_d   = 1'b0;
                rnd_valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pcnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            mux_sel_q   <= 1'b0;
            a_q         <= 1'b0;
            lead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            mux_sel_q   <= mux_sel_d;
            a_q         <= a_d;
            lead_q      <= lead_d;
        end
    end

    assign mux_sel   = mux_sel_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign busy      = (state_q != StIdle);

endmodule
